// File: rtl/mem_responder.sv
// Word-addressed memory slave with a level request / MemReady handshake
// and a fixed number of wait states per access. Out-of-range addresses
// and conflicting requests are flagged on Error without changing timing.
module mem_responder #(
  parameter int ADDR_W      = 13,
  parameter int DATA_W      = 16,
  parameter int DEPTH       = 4096,
  parameter int WAIT_CYCLES = 2
) (
  input  logic              Clk,
  input  logic              Reset,
  input  logic              MemRead,
  input  logic              MemWrite,
  input  logic [ADDR_W-1:0] Addr,
  input  logic [DATA_W-1:0] WriteData,
  output logic [DATA_W-1:0] ReadData,
  output logic              MemReady,
  output logic              Busy,
  output logic              Error
);

  localparam int          IDX_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [31:0] DEPTH_U = 32'(DEPTH);
  localparam logic [3:0]  WAIT_LD = 4'(WAIT_CYCLES);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t             state, state_nxt;
  logic [3:0]         cnt;
  logic [IDX_W-1:0]   lat_idx;
  logic [DATA_W-1:0]  lat_wdata;
  logic               lat_wr;
  logic               lat_oor;
  logic [DATA_W-1:0]  mem [DEPTH];

  logic req, accept, oor;

  assign req    = MemRead | MemWrite;
  assign accept = (state == S_IDLE) && req;
  // Compare at 32 bits so DEPTH == 2**ADDR_W cannot overflow the compare
  assign oor    = (32'(Addr) >= DEPTH_U);

  // State register; reset forces IDLE, which also aborts any pending write
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  // Next-state and handshake outputs
  always_comb begin
    state_nxt = state;
    MemReady  = 1'b0;
    Busy      = (state != S_IDLE);
    case (state)
      S_IDLE:   if (req) state_nxt = (WAIT_CYCLES == 0) ? S_ACCESS : S_WAIT;
      S_WAIT:   if (cnt == 4'd1) state_nxt = S_ACCESS;
      S_ACCESS: state_nxt = S_RESP;
      S_RESP: begin
        MemReady = 1'b1;
        if (!req) state_nxt = S_IDLE;
      end
      default:  state_nxt = S_IDLE;
    endcase
  end

  // Request latch, wait counter, error flag and registered read data
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      cnt       <= '0;
      lat_idx   <= '0;
      lat_wdata <= '0;
      lat_wr    <= 1'b0;
      lat_oor   <= 1'b0;
      Error     <= 1'b0;
      ReadData  <= '0;
    end else begin
      if (accept) begin
        lat_idx   <= Addr[IDX_W-1:0];
        lat_wdata <= WriteData;
        lat_wr    <= MemWrite;            // read+write resolves to write
        lat_oor   <= oor;
        Error     <= oor | (MemRead & MemWrite);
        cnt       <= WAIT_LD;
      end else if (state == S_WAIT) begin
        cnt <= cnt - 4'd1;
      end
      if (state == S_ACCESS && !lat_wr)
        ReadData <= lat_oor ? '0 : mem[lat_idx];
    end
  end

  // Storage array is never reset; contents survive Reset
  always_ff @(posedge Clk) begin
    if (state == S_ACCESS && lat_wr && !lat_oor)
      mem[lat_idx] <= lat_wdata;
  end

endmodule

// File: tb/tb_mem_responder.sv
// Two responders (2 wait states and 0 wait states) driven by directed and
// random transactions; a per-unit array model predicts data, error and latency.
module tb_mem_responder;

  localparam int NW = 4096;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd    [2];
  logic        wr    [2];
  logic [12:0] addr  [2];
  logic [15:0] wdata [2];
  logic [15:0] rdata [2];
  logic        rdy   [2];
  logic        busy  [2];
  logic        err   [2];

  int          wt [2];
  logic [15:0] mm [2][NW];
  logic [15:0] lastrd [2];
  int          wq [2][$];
  int          n_chk = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mem_responder #(.WAIT_CYCLES(2)) dut0 (
    .Clk(clk), .Reset(rst), .MemRead(rd[0]), .MemWrite(wr[0]), .Addr(addr[0]),
    .WriteData(wdata[0]), .ReadData(rdata[0]), .MemReady(rdy[0]), .Busy(busy[0]),
    .Error(err[0]));

  mem_responder #(.WAIT_CYCLES(0)) dut1 (
    .Clk(clk), .Reset(rst), .MemRead(rd[1]), .MemWrite(wr[1]), .Addr(addr[1]),
    .WriteData(wdata[1]), .ReadData(rdata[1]), .MemReady(rdy[1]), .Busy(busy[1]),
    .Error(err[1]));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  // One full handshake on unit u; hold = extra RESP cycles with request kept high
  task automatic txn(input int u, input bit r, input bit w, input logic [12:0] a,
                     input logic [15:0] d, input int hold);
    int  lat, bc;
    bit  oor, e_err;
    oor   = (int'(a) >= NW);
    e_err = oor || (r && w);
    if (w && !oor) begin
      mm[u][a[11:0]] = d;
      wq[u].push_back(int'(a));
    end
    if (!w) lastrd[u] = oor ? 16'h0 : mm[u][a[11:0]];

    @(negedge clk);
    rd[u] = r; wr[u] = w; addr[u] = a; wdata[u] = d;
    @(posedge clk);                          // acceptance edge
    #1;
    addr[u] = 13'($urandom); wdata[u] = 16'($urandom);   // must be ignored
    bc  = busy[u] ? 1 : 0;
    lat = 0;
    do begin
      @(posedge clk); #1;
      lat++;
      if (busy[u]) bc++;
    end while (!rdy[u] && lat < 40);
    chk($sformatf("latency u%0d", u), lat, wt[u] + 1);
    for (int h = 0; h < hold; h++) begin
      @(posedge clk); #1;
      if (busy[u]) bc++;
      chk($sformatf("hold_rdy u%0d", u), rdy[u], 1);
    end
    chk($sformatf("busy_cyc u%0d", u), bc, wt[u] + 2 + hold);
    rd[u] = 1'b0; wr[u] = 1'b0;
    chk($sformatf("rdata u%0d", u), rdata[u], lastrd[u]);
    chk($sformatf("error u%0d", u), err[u], e_err);
    @(posedge clk); #1;
    chk($sformatf("idle_rdy u%0d", u), rdy[u], 0);
    chk($sformatf("idle_busy u%0d", u), busy[u], 0);
    chk($sformatf("idle_err u%0d", u), err[u], e_err);
  endtask

  task automatic rand_txn(input int u);
    int          k;
    logic [12:0] a;
    k = $urandom_range(0, 9);
    a = 13'($urandom_range(0, NW - 1));
    case (k)
      0: txn(u, 0, 1, 13'(NW + $urandom_range(0, NW - 1)), 16'($urandom), $urandom_range(0, 2));
      1: txn(u, 1, 0, 13'(NW + $urandom_range(0, NW - 1)), 16'($urandom), $urandom_range(0, 2));
      2: txn(u, 1, 1, a, 16'($urandom), $urandom_range(0, 2));
      3, 4, 5: txn(u, 0, 1, a, 16'($urandom), $urandom_range(0, 2));
      default: begin
        if (wq[u].size() > 0)
          a = 13'(wq[u][$urandom_range(0, wq[u].size() - 1)]);
        txn(u, wq[u].size() > 0, wq[u].size() == 0, a, 16'($urandom), $urandom_range(0, 3));
      end
    endcase
  endtask

  initial begin
    wt[0] = 2; wt[1] = 0;
    rst = 1'b1;
    for (int u = 0; u < 2; u++) begin
      rd[u] = 0; wr[u] = 0; addr[u] = '0; wdata[u] = '0; lastrd[u] = '0;
    end
    #1;
    for (int u = 0; u < 2; u++) begin
      chk($sformatf("rst_rdata u%0d", u), rdata[u], 0);
      chk($sformatf("rst_rdy u%0d", u), rdy[u], 0);
      chk($sformatf("rst_busy u%0d", u), busy[u], 0);
      chk($sformatf("rst_err u%0d", u), err[u], 0);
    end
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // 2 wait states: write then read back
    txn(0, 0, 1, 13'h005, 16'hBEEF, 0);
    txn(0, 1, 0, 13'h005, 16'h0000, 0);
    // 0 wait states: write then read back
    txn(1, 0, 1, 13'h000, 16'h1234, 0);
    txn(1, 1, 0, 13'h000, 16'h0000, 0);
    // read held five cycles in RESP
    txn(0, 1, 0, 13'h005, 16'h0000, 4);
    // out-of-range write aliases onto 0x0FFF if not suppressed
    txn(0, 0, 1, 13'h0FFF, 16'h1357, 0);
    txn(0, 0, 1, 13'h1FFF, 16'hAAAA, 0);
    txn(0, 1, 0, 13'h0FFF, 16'h0000, 0);
    txn(0, 1, 0, 13'h1FFF, 16'h0000, 0);
    // read+write together acts as write with Error, next read clears it
    txn(0, 1, 1, 13'h010, 16'h00FF, 0);
    txn(0, 1, 0, 13'h010, 16'h0000, 0);
    txn(1, 1, 1, 13'h010, 16'h00FF, 1);
    txn(1, 1, 0, 13'h010, 16'h0000, 0);

    // reset in WAIT aborts a pending write
    txn(0, 0, 1, 13'h020, 16'h0001, 0);
    @(negedge clk);
    wr[0] = 1'b1; addr[0] = 13'h020; wdata[0] = 16'h5555;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    chk("mid_rst_rdy", rdy[0], 0);
    chk("mid_rst_busy", busy[0], 0);
    chk("mid_rst_err", err[0], 0);
    chk("mid_rst_rdata", rdata[0], 0);
    wr[0] = 1'b0;
    lastrd[0] = '0; lastrd[1] = '0;
    @(negedge clk);
    rst = 1'b0;
    txn(0, 1, 0, 13'h020, 16'h0000, 0);

    // random traffic on both units
    for (int i = 0; i < 30; i++) begin
      rand_txn(0);
      rand_txn(1);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/mem_responder.md
MEM_RESPONDER -- requirements
Module: mem_responder

Interface
REQ-001 Parameter ADDR_W, 13, address width in bits.
REQ-002 Parameter DATA_W, 16, data width in bits.
REQ-003 Parameter DEPTH, 4096, number of implemented words; valid addresses are 0..DEPTH-1.
REQ-004 Parameter WAIT_CYCLES, 2, wait states per access; legal range 0..15.
REQ-005 Clk  input  1  clock; all state updates on rising edge.
REQ-006 Reset  input  1  asynchronous, active-high reset.
REQ-007 MemRead  input  1  read request level; held until MemReady seen.
REQ-008 MemWrite  input  1  write request level; held until MemReady seen.
REQ-009 Addr  input  ADDR_W  word address; sampled only at request acceptance.
REQ-010 WriteData  input  DATA_W  store data; sampled only at request acceptance.
REQ-011 ReadData  output  DATA_W  registered read result; valid while MemReady high after a read.
REQ-012 MemReady  output  1  access complete; 4-phase handshake acknowledge.
REQ-013 Busy  output  1  high in every state except IDLE.
REQ-014 Error  output  1  sticky per transaction; set on out-of-range address or MemRead/MemWrite both high.

Function
REQ-015 States SHALL be IDLE, WAIT, ACCESS, RESP; 2-bit encoding, state register updated on Clk rising edge.
REQ-016 IDLE: request accepted on an edge where MemRead or MemWrite is high; Addr, WriteData, operation latched into internal registers.
REQ-017 Acceptance: WAIT_CYCLES>0 -> WAIT with 4-bit counter loaded with WAIT_CYCLES; WAIT_CYCLES=0 -> directly ACCESS.
REQ-018 WAIT: counter decrements each cycle; transition to ACCESS on edge where counter equals 1.
REQ-019 ACCESS (exactly one cycle): read -> array[latched Addr] registered into ReadData; write -> latched WriteData stored at latched Addr; then RESP.
REQ-020 RESP: MemReady=1; held while MemRead or MemWrite high; RESP->IDLE on first edge both requests low; MemReady low in IDLE.
REQ-021 Latency: acceptance edge N -> MemReady high after edge N+WAIT_CYCLES+1 (first cycle in RESP).
REQ-022 Requests changing between acceptance and RESP SHALL be ignored; latched values govern the access.
REQ-023 MemRead and MemWrite both high at acceptance: treated as write, Error set.
REQ-024 Latched Addr >= DEPTH: write suppressed (array unchanged), ReadData forced to 0, Error set; timing identical to valid access.
REQ-025 Error cleared on next acceptance, otherwise holds value through RESP and IDLE.
REQ-026 ReadData SHALL hold last value across write transactions and IDLE; updated only in read ACCESS.
REQ-027 No new acceptance in WAIT, ACCESS, or RESP; new request accepted only after return to IDLE.
REQ-028 Back-to-back: request reasserted in first IDLE cycle SHALL be accepted at that edge; no extra idle cycle required.

Reset
REQ-029 Reset high: state IDLE, counter 0, ReadData 0, MemReady 0, Busy 0, Error 0, immediately, independent of Clk.
REQ-030 Memory array contents not reset; hold prior values.
REQ-031 Reset during WAIT/ACCESS before ACCESS edge aborts transaction; pending write SHALL NOT update array.
REQ-032 First acceptance possible on first Clk rising edge after Reset deasserted.

Verification
REQ-033 WAIT_CYCLES=2: write 16'hBEEF to 0x005, drop on MemReady; read 0x005 -> ReadData 16'hBEEF, MemReady high 3 cycles after each acceptance edge.
REQ-034 WAIT_CYCLES=0: read 0x000 after write 16'h1234 -> MemReady first high after 1 edge post-acceptance, ReadData 16'h1234, Busy high 2 cycles.
REQ-035 Hold MemRead 5 cycles in RESP -> MemReady stays high 5 cycles, one access only, IDLE one edge after MemRead drops.
REQ-036 Write Addr 0x1FFF (>=DEPTH=4096) data 16'hAAAA -> Error 1, no array change (readback of 0x0FFF unchanged), then read 0x1FFF -> ReadData 0, Error 1.
REQ-037 MemRead+MemWrite both high, Addr 0x010, WriteData 16'h00FF -> write performed, Error 1; following valid read of 0x010 -> 16'h00FF, Error 0.
REQ-038 Reset pulse in WAIT of write 16'h5555 to 0x020 (prior 16'h0001) -> outputs 0 immediately, read of 0x020 returns 16'h0001.
